// File: rtl/steer_en_sm.sv
// Steering-enable state machine: decides from the captured load-cell pair whether a
// level rider is present (en_steer) or absent (rider_off). STEER_EN_FAST_SIM_EN selects a short dwell timer.
module steer_en_sm #(
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [7:0]  WT_HYST      = 8'h40,
`ifdef STEER_EN_FAST_SIM_EN
    parameter int          TMR_BITS     = 15
`else
    parameter int          TMR_BITS     = 26
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam logic [12:0] THR_HI = 13'(MIN_RIDER_WT) + 13'(WT_HYST);
    localparam logic [12:0] THR_LO = 13'(MIN_RIDER_WT) - 13'(WT_HYST);
    localparam logic [TMR_BITS-1:0] TMR_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STEER
    } state_t;

    state_t state;
    state_t next_state;

    logic [11:0] lft_q;
    logic [11:0] rght_q;
    logic [12:0] sum;
    logic [11:0] adiff;
    logic [12:0] sum_qtr;
    logic [12:0] sum_15_16;
    logic        sum_gt_min;
    logic        sum_lt_min;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;

    logic [TMR_BITS-1:0] timer;
    logic                tmr_full;
    logic                clr_tmr;
    logic                en_nxt;
    logic                off_nxt;

    // Capture the load pair on each strobe; decisions hold between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            lft_q  <= '0;
            rght_q <= '0;
        end else if (vld) begin
            lft_q  <= lft_ld;
            rght_q <= rght_ld;
        end
    end

    assign sum   = {1'b0, lft_q} + {1'b0, rght_q};
    assign adiff = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);

    assign sum_qtr   = sum >> 2;
    assign sum_15_16 = sum - (sum >> 4);

    assign sum_gt_min    = (sum > THR_HI);
    assign sum_lt_min    = (sum < THR_LO);
    assign diff_gt_1_4   = ({1'b0, adiff} > sum_qtr);
    assign diff_gt_15_16 = ({1'b0, adiff} > sum_15_16);

    assign tmr_full = &timer;

    // Dwell timer: cleared on request, otherwise counts up and sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (clr_tmr) begin
            timer <= '0;
        end else if (!tmr_full) begin
            timer <= timer + TMR_ONE;
        end
    end

    // Next-state and output decode; rider loss outranks imbalance, which outranks the timer
    always_comb begin
        next_state = state;
        clr_tmr    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (sum_gt_min) begin
                    next_state = ST_WAIT;
                    clr_tmr    = 1'b1;
                end
            end
            ST_WAIT: begin
                if (sum_lt_min) begin
                    next_state = ST_IDLE;
                end else if (diff_gt_1_4) begin
                    clr_tmr = 1'b1;
                end else if (tmr_full) begin
                    next_state = ST_STEER;
                end
            end
            ST_STEER: begin
                if (sum_lt_min) begin
                    next_state = ST_IDLE;
                end else if (diff_gt_15_16) begin
                    next_state = ST_WAIT;
                    clr_tmr    = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        en_nxt  = (next_state == ST_STEER);
        off_nxt = (next_state == ST_IDLE);
    end

    // State and registered outputs; the two outputs decode disjoint states
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
        end else begin
            state     <= next_state;
            en_steer  <= en_nxt;
            rider_off <= off_nxt;
        end
    end

endmodule

// File: tb/tb_steer_en_sm.sv
// Bench for steer_en_sm: directed scenarios plus randomized load profiles
// checked cycle by cycle against a behavioural rider model.
module tb_steer_en_sm;

    localparam int TMR   = 10;
    localparam int DWELL = 1 << TMR;
    localparam int FULL  = DWELL - 1;
    localparam int THR_HI = 'h240;
    localparam int THR_LO = 'h1C0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic        en_steer;
    logic        rider_off;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    steer_en_sm #(.TMR_BITS(TMR)) dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    // Behavioural model: mode 0 = no rider, 1 = settling, 2 = steering.
    // m_age counts clocks since the settle timer was last restarted.
    int m_l = 0;
    int m_r = 0;
    int m_mode = 0;
    int m_age = 0;
    int t_sum;
    int t_adiff;
    int t_nm;
    bit t_clr;

    always @(posedge clk) begin
        if (rst) begin
            m_l    <= 0;
            m_r    <= 0;
            m_mode <= 0;
            m_age  <= 0;
        end else begin
            t_sum   = m_l + m_r;
            t_adiff = (m_l >= m_r) ? m_l - m_r : m_r - m_l;
            t_nm    = m_mode;
            t_clr   = 1'b0;
            if (m_mode == 0) begin
                if (t_sum > THR_HI) begin
                    t_nm  = 1;
                    t_clr = 1'b1;
                end
            end else if (t_sum < THR_LO) begin
                t_nm = 0;
            end else if (m_mode == 1) begin
                if (t_adiff > t_sum / 4) t_clr = 1'b1;
                else if (m_age == FULL) t_nm = 2;
            end else if (t_adiff > t_sum - t_sum / 16) begin
                t_nm  = 1;
                t_clr = 1'b1;
            end
            m_mode <= t_nm;
            m_age  <= t_clr ? 0 : (m_age < FULL ? m_age + 1 : FULL);
            if (vld) begin
                m_l <= int'(lft_ld);
                m_r <= int'(rght_ld);
            end
        end
    end

    wire exp_en  = (m_mode == 2);
    wire exp_off = (m_mode == 0);

    task automatic load(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
        vld     = 1'b1;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Hold a load pair (strobed every 10 clocks) until en_steer rises; -1 on timeout
    task automatic wait_en(input logic [11:0] l, input logic [11:0] r,
                           input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            lft_ld  = l;
            rght_ld = r;
            vld     = (i % 10 == 0);
            @(negedge clk);
            vld = 1'b0;
            if (en_steer === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vld = 1'b0;
        tick(2);
        n_cmp++;
        if (en_steer !== 1'b0) begin
            n_err++;
            $display("FAIL reset_en: got %b want 0", en_steer);
        end
        n_cmp++;
        if (rider_off !== 1'b1) begin
            n_err++;
            $display("FAIL reset_off: got %b want 1", rider_off);
        end
        rst = 1'b0;
        tick(3);
        n_cmp++;
        if (rider_off !== 1'b1 || en_steer !== 1'b0) begin
            n_err++;
            $display("FAIL idle_empty: got en=%b off=%b want 0/1", en_steer, rider_off);
        end
    endtask

    task automatic test_threshold();
        pulse_rst();
        load(12'h120, 12'h120);
        tick(3);
        n_cmp++;
        if (rider_off !== 1'b1) begin
            n_err++;
            $display("FAIL sum_eq_hi: got off=%b want 1", rider_off);
        end
        load(12'h121, 12'h120);
        tick(1);
        n_cmp++;
        if (rider_off !== 1'b0) begin
            n_err++;
            $display("FAIL sum_above_hi: got off=%b want 0", rider_off);
        end
        load(12'h0E0, 12'h0E0);
        tick(2);
        n_cmp++;
        if (rider_off !== 1'b0) begin
            n_err++;
            $display("FAIL sum_eq_lo: got off=%b want 0", rider_off);
        end
        load(12'h0E0, 12'h0DF);
        tick(1);
        n_cmp++;
        if (rider_off !== 1'b1) begin
            n_err++;
            $display("FAIL sum_below_lo: got off=%b want 1", rider_off);
        end
    endtask

    task automatic test_mount();
        int c;
        pulse_rst();
        load(12'h180, 12'h180);
        n_cmp++;
        if (rider_off !== 1'b1) begin
            n_err++;
            $display("FAIL mount_edge1: got off=%b want 1", rider_off);
        end
        tick(1);
        n_cmp++;
        if (rider_off !== 1'b0 || en_steer !== 1'b0) begin
            n_err++;
            $display("FAIL mount_edge2: got en=%b off=%b want 0/0", en_steer, rider_off);
        end
        wait_en(12'h180, 12'h180, DWELL + 50, c);
        n_cmp++;
        if (c != DWELL) begin
            n_err++;
            $display("FAIL mount_dwell: got %0d want %0d", c, DWELL);
        end
    endtask

    task automatic test_uneven();
        int c;
        bit saw_en;
        pulse_rst();
        load(12'h200, 12'h100);
        saw_en = 1'b0;
        for (int i = 1; i <= 600; i++) begin
            vld = (i % 10 == 0);
            @(negedge clk);
            vld = 1'b0;
            if (en_steer !== 1'b0) saw_en = 1'b1;
        end
        n_cmp++;
        if (saw_en || rider_off !== 1'b0) begin
            n_err++;
            $display("FAIL uneven_hold: got saw_en=%b off=%b want 0/0", saw_en, rider_off);
        end
        load(12'h180, 12'h180);
        wait_en(12'h180, 12'h180, DWELL + 50, c);
        n_cmp++;
        if (c != DWELL) begin
            n_err++;
            $display("FAIL uneven_dwell: got %0d want %0d", c, DWELL);
        end
    endtask

    task automatic test_hysteresis();
        load(12'h0F0, 12'h0F0);
        tick(20);
        n_cmp++;
        if (en_steer !== 1'b1 || rider_off !== 1'b0) begin
            n_err++;
            $display("FAIL band_hold: got en=%b off=%b want 1/0", en_steer, rider_off);
        end
        load(12'h080, 12'h080);
        tick(1);
        n_cmp++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1) begin
            n_err++;
            $display("FAIL dismount: got en=%b off=%b want 0/1", en_steer, rider_off);
        end
    endtask

    task automatic test_lean_off();
        int c;
        load(12'h180, 12'h180);
        tick(1);
        wait_en(12'h180, 12'h180, DWELL + 50, c);
        n_cmp++;
        if (c != DWELL) begin
            n_err++;
            $display("FAIL remount_dwell: got %0d want %0d", c, DWELL);
        end
        load(12'h3F0, 12'h005);
        tick(1);
        n_cmp++;
        if (en_steer !== 1'b0 || rider_off !== 1'b0) begin
            n_err++;
            $display("FAIL lean_off: got en=%b off=%b want 0/0", en_steer, rider_off);
        end
        tick(30);
        n_cmp++;
        if (en_steer !== 1'b0 || rider_off !== 1'b0) begin
            n_err++;
            $display("FAIL lean_hold: got en=%b off=%b want 0/0", en_steer, rider_off);
        end
    endtask

    task automatic test_reset_steer();
        int c;
        load(12'h180, 12'h180);
        wait_en(12'h180, 12'h180, DWELL + 50, c);
        n_cmp++;
        if (c != DWELL) begin
            n_err++;
            $display("FAIL relevel_dwell: got %0d want %0d", c, DWELL);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1) begin
            n_err++;
            $display("FAIL rst_in_steer: got en=%b off=%b want 0/1", en_steer, rider_off);
        end
        rst = 1'b0;
        load(12'h180, 12'h180);
        tick(1);
        wait_en(12'h180, 12'h180, DWELL + 50, c);
        n_cmp++;
        if (c != DWELL) begin
            n_err++;
            $display("FAIL post_rst_dwell: got %0d want %0d", c, DWELL);
        end
    endtask

    task automatic test_random();
        int seg;
        int prof;
        int base;
        pulse_rst();
        seg  = 0;
        prof = 0;
        for (int i = 0; i < 20000; i++) begin
            if (seg == 0) begin
                seg  = $urandom_range(2500, 20);
                prof = $urandom_range(7, 0);
            end
            seg--;
            case (prof)
                0, 1, 2: begin
                    base    = $urandom_range('h400, 'h130);
                    lft_ld  = 12'(base + $urandom_range(15, 0));
                    rght_ld = 12'(base + $urandom_range(15, 0));
                end
                3: begin
                    lft_ld  = 12'($urandom_range('hFFF, 'h200));
                    rght_ld = 12'($urandom_range('h80, 0));
                end
                4: begin
                    lft_ld  = 12'($urandom_range('hD0, 0));
                    rght_ld = 12'($urandom_range('hD0, 0));
                end
                5: begin
                    lft_ld  = 12'($urandom_range('h120, 'hE0));
                    rght_ld = 12'($urandom_range('h120, 'hE0));
                end
                default: begin
                    lft_ld  = 12'($urandom);
                    rght_ld = 12'($urandom);
                end
            endcase
            vld = ($urandom_range(3, 0) != 0);
            rst = ($urandom_range(4999, 0) == 0);
            @(negedge clk);
            n_cmp++;
            if (en_steer !== exp_en) begin
                n_err++;
                $display("FAIL rand_en cyc %0d: got %b want %b", i, en_steer, exp_en);
            end
            n_cmp++;
            if (rider_off !== exp_off) begin
                n_err++;
                $display("FAIL rand_off cyc %0d: got %b want %b", i, rider_off, exp_off);
            end
        end
        rst = 1'b0;
        vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_mount();
        test_uneven();
        test_hysteresis();
        test_lean_off();
        test_reset_steer();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
